// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: memory-stage controller for the 5-stage pipeline.
//
// Turns the EX/MEM load/store controls into a req/ack transaction on a
// variable-latency data-memory port. It stalls the front of the pipeline while
// an access is outstanding, and registers the MEM/WB fields, including the
// load data.
//
// Parameters:
//   TIMEOUT  max WAIT cycles without dmem_ack before the access is aborted (1..255)
//
// Optional feature (compile-time macro):
//   MEM_ALIGN_CHECK_EN  when defined, an access with aluResult_EX_MEM[1:0] != 0
//                       issues no request, retires as a bubble and pulses misalign.
//                       When undefined, misalign is tied to 0.
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   *_EX_MEM                       EX/MEM pipeline fields (controls, rd, address, store data)
//   dmem_req/we/addr/wdata         registered memory request (held stable until ack/timeout)
//   dmem_rdata, dmem_ack           memory response
//   stall                          combinational; holds PC, IF/ID, ID/EX, EX/MEM
//   *_MEM_WB                       MEM/WB pipeline fields
//   bus_err                        sticky access-timeout flag
//   misalign                       one-cycle misaligned-access pulse
module mem_stage_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        regWrite_EX_MEM,
    input  logic        memWrite_EX_MEM,
    input  logic        memRead_EX_MEM,
    input  logic        memToReg_EX_MEM,
    input  logic        jump_EX_MEM,
    input  logic [4:0]  rd_EX_MEM,
    input  logic [31:0] aluResult_EX_MEM,
    input  logic [31:0] data2_EX_MEM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall,
    output logic        regWrite_MEM_WB,
    output logic        memToReg_MEM_WB,
    output logic        jump_MEM_WB,
    output logic [4:0]  rd_MEM_WB,
    output logic [31:0] aluResult_MEM_WB,
    output logic [31:0] readData_MEM_WB,
    output logic        bus_err,
    output logic        misalign
);

    localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e      state_q, state_d;
    logic [7:0]  count_q, count_d;

    logic        acc;
    logic        misaligned;
    logic        issue;       // start a request on this edge
    logic        done;        // request ends on this edge (ack or timeout)
    logic        timeout;
    logic        capture;     // MEM/WB takes EX/MEM fields; otherwise a bubble
    logic [31:0] wb_rdata;

    assign acc = memRead_EX_MEM | memWrite_EX_MEM;

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = (aluResult_EX_MEM[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        stall   = 1'b0;
        issue   = 1'b0;
        done    = 1'b0;
        timeout = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!acc) begin
                    capture = 1'b1;
                end else if (!misaligned) begin
                    stall   = 1'b1;
                    issue   = 1'b1;
                    count_d = 8'd0;
                    state_d = StWait;
                end
                // a misaligned access falls through as a bubble without stalling
            end
            StWait: begin
                // ack wins over a timeout landing in the same cycle
                if (dmem_ack) begin
                    capture = 1'b1;
                    done    = 1'b1;
                    state_d = StIdle;
                end else if (count_q == CntLast) begin
                    timeout = 1'b1;
                    done    = 1'b1;
                    state_d = StIdle;
                end else begin
                    stall   = 1'b1;
                    count_d = count_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Only a completed read returns memory data; everything else writes back zero.
    assign wb_rdata = (state_q == StWait && !memWrite_EX_MEM) ? dmem_rdata : 32'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= StIdle;
            count_q          <= 8'd0;
            dmem_req         <= 1'b0;
            dmem_we          <= 1'b0;
            dmem_addr        <= 32'd0;
            dmem_wdata       <= 32'd0;
            regWrite_MEM_WB  <= 1'b0;
            memToReg_MEM_WB  <= 1'b0;
            jump_MEM_WB      <= 1'b0;
            rd_MEM_WB        <= 5'd0;
            aluResult_MEM_WB <= 32'd0;
            readData_MEM_WB  <= 32'd0;
            bus_err          <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;

            if (issue) begin
                dmem_req   <= 1'b1;
                dmem_we    <= memWrite_EX_MEM;
                dmem_addr  <= aluResult_EX_MEM;
                dmem_wdata <= data2_EX_MEM;
            end else if (done) begin
                dmem_req <= 1'b0;
            end

            if (timeout) begin
                bus_err <= 1'b1;
            end

            if (capture) begin
                regWrite_MEM_WB  <= regWrite_EX_MEM;
                memToReg_MEM_WB  <= memToReg_EX_MEM;
                jump_MEM_WB      <= jump_EX_MEM;
                rd_MEM_WB        <= rd_EX_MEM;
                aluResult_MEM_WB <= aluResult_EX_MEM;
                readData_MEM_WB  <= wb_rdata;
            end else begin
                // bubble: kill controls, data fields keep their prior values
                regWrite_MEM_WB <= 1'b0;
                memToReg_MEM_WB <= 1'b0;
                jump_MEM_WB     <= 1'b0;
            end
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            misalign <= 1'b0;
        end else begin
            misalign <= (state_q == StIdle) && acc && misaligned;
        end
    end
`else
    assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl (TIMEOUT = 4).
// Directed vector table, hand-written corner sequences, then randomized
// instructions checked against a transaction-level model of the stage.
module tb_mem_stage_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        rw_i, mw_i, mr_i, mtr_i, jmp_i;
    logic [4:0]  rd_i;
    logic [31:0] alu_i, d2_i;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_ack;
    logic        stall;
    logic        regWrite_MEM_WB, memToReg_MEM_WB, jump_MEM_WB;
    logic [4:0]  rd_MEM_WB;
    logic [31:0] aluResult_MEM_WB, readData_MEM_WB;
    logic        bus_err, misalign;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_stage_ctrl #(.TIMEOUT(TO)) dut (
        .clk              (clk),
        .reset            (reset),
        .regWrite_EX_MEM  (rw_i),
        .memWrite_EX_MEM  (mw_i),
        .memRead_EX_MEM   (mr_i),
        .memToReg_EX_MEM  (mtr_i),
        .jump_EX_MEM      (jmp_i),
        .rd_EX_MEM        (rd_i),
        .aluResult_EX_MEM (alu_i),
        .data2_EX_MEM     (d2_i),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_wdata       (dmem_wdata),
        .dmem_rdata       (dmem_rdata),
        .dmem_ack         (dmem_ack),
        .stall            (stall),
        .regWrite_MEM_WB  (regWrite_MEM_WB),
        .memToReg_MEM_WB  (memToReg_MEM_WB),
        .jump_MEM_WB      (jump_MEM_WB),
        .rd_MEM_WB        (rd_MEM_WB),
        .aluResult_MEM_WB (aluResult_MEM_WB),
        .readData_MEM_WB  (readData_MEM_WB),
        .bus_err          (bus_err),
        .misalign         (misalign)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rw, mw, mr, mtr, jmp, input logic [4:0] rd,
                         input logic [31:0] alu, d2);
        rw_i = rw; mw_i = mw; mr_i = mr; mtr_i = mtr; jmp_i = jmp;
        rd_i = rd; alu_i = alu; d2_i = d2;
    endtask

    // Present one instruction in EX/MEM and hold it while stalled. lat = cycle of
    // dmem_req on which ack is returned (0 = never). Called #1 after a rising edge,
    // returns #1 after the edge on which the instruction reaches MEM/WB.
    task automatic run_instr(input logic rw, mw, mr, mtr, jmp, input logic [4:0] rd,
                             input logic [31:0] alu, d2, input int lat,
                             input logic [31:0] rdata, input logic idle_ack,
                             output int stalls, output int reqs);
        logic mis;
        bit   fin;
        int   j;
        drive(rw, mw, mr, mtr, jmp, rd, alu, d2);
        dmem_ack   = idle_ack;            // ack outside WAIT must be ignored
        dmem_rdata = $urandom;
        stalls = 0;
        reqs   = 0;
`ifdef MEM_ALIGN_CHECK_EN
        mis = (alu[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        @(negedge clk);
        chk("req_low_idle", 32'(dmem_req), 32'd0);
        if (stall) stalls++;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        if ((mr | mw) && !mis) begin
            j   = 1;
            fin = 1'b0;
            while (!fin) begin
                if (j == lat) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = rdata;
                end else begin
                    dmem_rdata = $urandom;
                end
                @(negedge clk);
                if (dmem_req) reqs++;
                chk("hs_addr", dmem_addr, alu);
                chk("hs_wdata", dmem_wdata, d2);
                chk("hs_we", 32'(dmem_we), 32'(mw));
                if (stall) stalls++;
                fin = (j == lat) || (j == TO);
                @(posedge clk); #1;
                dmem_ack = 1'b0;
                j++;
            end
        end
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0);
        reset      = 1'b1;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        #1;
        reset    = 1'b0;
        dmem_ack = 1'b0;
    endtask

    typedef struct {
        logic        rw, mw, mr, mtr, jmp;
        logic [4:0]  rd;
        logic [31:0] alu, d2;
        int          lat;
        logic [31:0] rdata;
        logic        iack;
        int          e_st, e_rq;
        logic        e_rw, e_mtr, e_jmp;
        logic [4:0]  e_rd;
        logic [31:0] e_alu, e_rdata;
        logic        e_berr;
    } vec_t;

    typedef struct {
        logic        rw, mtr, jmp;
        logic [4:0]  rd;
        logic [31:0] alu, rdata;
    } wb_t;

    task automatic chk_wb(input string tag, input wb_t e, input logic berr);
        chk({tag, "_regWrite"}, 32'(regWrite_MEM_WB), 32'(e.rw));
        chk({tag, "_memToReg"}, 32'(memToReg_MEM_WB), 32'(e.mtr));
        chk({tag, "_jump"}, 32'(jump_MEM_WB), 32'(e.jmp));
        chk({tag, "_rd"}, 32'(rd_MEM_WB), 32'(e.rd));
        chk({tag, "_alu"}, aluResult_MEM_WB, e.alu);
        chk({tag, "_rdata"}, readData_MEM_WB, e.rdata);
        chk({tag, "_bus_err"}, 32'(bus_err), 32'(berr));
    endtask

    vec_t tbl [9];

    initial begin
        int   st, rq;
        wb_t  exp_wb;
        logic exp_berr;

        //        rw mw mr mtr jmp rd  alu          d2     lat rdata         iack
        //        st rq  e_rw e_mtr e_jmp e_rd e_alu e_rdata e_berr
        tbl[0] = '{1, 0, 0, 0, 0, 5'd5,  32'h1234, 32'h0,  0, 32'h0,        0,
                   0, 0, 1, 0, 0, 5'd5,  32'h1234, 32'h0,        0};
        tbl[1] = '{1, 0, 0, 0, 1, 5'd31, 32'h40,   32'h0,  0, 32'h0,        1,
                   0, 0, 1, 0, 1, 5'd31, 32'h40,   32'h0,        0};
        tbl[2] = '{1, 0, 1, 1, 0, 5'd7,  32'h100,  32'h0,  3, 32'hDEADBEEF, 0,
                   3, 3, 1, 1, 0, 5'd7,  32'h100,  32'hDEADBEEF, 0};
        tbl[3] = '{0, 1, 0, 0, 0, 5'd0,  32'h200,  32'hAA, 1, 32'h9999,     0,
                   1, 1, 0, 0, 0, 5'd0,  32'h200,  32'h0,        0};
        tbl[4] = '{0, 1, 0, 0, 0, 5'd0,  32'h204,  32'hBB, 1, 32'h8888,     0,
                   1, 1, 0, 0, 0, 5'd0,  32'h204,  32'h0,        0};
        tbl[5] = '{0, 1, 1, 0, 0, 5'd2,  32'h300,  32'h55, 2, 32'h1111,     0,
                   2, 2, 0, 0, 0, 5'd2,  32'h300,  32'h0,        0};
        tbl[6] = '{1, 0, 1, 1, 0, 5'd9,  32'h10,   32'h0,  4, 32'hCAFE0001, 0,
                   4, 4, 1, 1, 0, 5'd9,  32'h10,   32'hCAFE0001, 0};
        tbl[7] = '{1, 0, 1, 1, 1, 5'd12, 32'h400,  32'h0,  0, 32'h0,        0,
                   4, 4, 0, 0, 0, 5'd9,  32'h10,   32'hCAFE0001, 1};
        tbl[8] = '{1, 0, 0, 0, 0, 5'd3,  32'h77,   32'h0,  0, 32'h0,        1,
                   0, 0, 1, 0, 0, 5'd3,  32'h77,   32'h0,        1};

        // Reset with ack held high
        do_reset();
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_we", 32'(dmem_we), 32'd0);
        chk("rst_addr", dmem_addr, 32'd0);
        chk("rst_wdata", dmem_wdata, 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_misalign", 32'(misalign), 32'd0);
        exp_wb = '{0, 0, 0, 5'd0, 32'd0, 32'd0};
        chk_wb("rst", exp_wb, 1'b0);

        // Directed vector table
        for (int i = 0; i < 9; i++) begin
            run_instr(tbl[i].rw, tbl[i].mw, tbl[i].mr, tbl[i].mtr, tbl[i].jmp, tbl[i].rd,
                      tbl[i].alu, tbl[i].d2, tbl[i].lat, tbl[i].rdata, tbl[i].iack, st, rq);
            chk($sformatf("vec%0d_stalls", i), 32'(st), 32'(tbl[i].e_st));
            chk($sformatf("vec%0d_reqs", i), 32'(rq), 32'(tbl[i].e_rq));
            exp_wb = '{tbl[i].e_rw, tbl[i].e_mtr, tbl[i].e_jmp, tbl[i].e_rd,
                       tbl[i].e_alu, tbl[i].e_rdata};
            chk_wb($sformatf("vec%0d", i), exp_wb, tbl[i].e_berr);
        end

        // Misaligned load at 0x102
`ifdef MEM_ALIGN_CHECK_EN
        run_instr(1, 0, 1, 1, 0, 5'd4, 32'h102, 32'h0, 1, 32'h5, 0, st, rq);
        chk("mis_stalls", 32'(st), 32'd0);
        chk("mis_reqs", 32'(rq), 32'd0);
        chk("mis_pulse", 32'(misalign), 32'd1);
        chk("mis_regWrite", 32'(regWrite_MEM_WB), 32'd0);
        chk("mis_req_off", 32'(dmem_req), 32'd0);
        run_instr(0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 0, 32'h0, 0, st, rq);
        chk("mis_pulse_end", 32'(misalign), 32'd0);
`else
        run_instr(1, 0, 1, 1, 0, 5'd4, 32'h102, 32'h0, 1, 32'h5, 0, st, rq);
        chk("mis_stalls", 32'(st), 32'd1);
        chk("mis_reqs", 32'(rq), 32'd1);
        chk("mis_tied", 32'(misalign), 32'd0);
        chk("mis_regWrite", 32'(regWrite_MEM_WB), 32'd1);
        chk("mis_rdata", readData_MEM_WB, 32'h5);
`endif

        // Reset in the middle of an outstanding access, then a stray ack
        do_reset();
        drive(1, 0, 1, 1, 0, 5'd6, 32'h500, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rw_req_up", 32'(dmem_req), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rw_req_dropped", 32'(dmem_req), 32'd0);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h1234_5678;
        @(negedge clk);
        chk("rw_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        chk("rw_req_still_low", 32'(dmem_req), 32'd0);
        chk("rw_rdata", readData_MEM_WB, 32'd0);
        chk("rw_regWrite", 32'(regWrite_MEM_WB), 32'd0);

        // Randomized instructions against a transaction-level model
        do_reset();
        exp_wb   = '{0, 0, 0, 5'd0, 32'd0, 32'd0};
        exp_berr = 1'b0;
        for (int n = 0; n < 250; n++) begin
            logic        rw, mw, mr, mtr, jmp, iack;
            logic [4:0]  rd;
            logic [31:0] alu, d2, rdata;
            int          lat, e_st;
            int          kind;
            kind = $urandom_range(0, 3);
            rw   = 1'($urandom);
            mtr  = 1'($urandom);
            jmp  = 1'($urandom);
            iack = 1'($urandom);
            rd   = 5'($urandom);
            alu  = $urandom;
            alu[1:0] = 2'b00;
            d2    = $urandom;
            rdata = $urandom;
            mr = (kind == 1) || (kind == 3);
            mw = (kind == 2) || (kind == 3);
            lat = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TO);
            run_instr(rw, mw, mr, mtr, jmp, rd, alu, d2, lat, rdata, iack, st, rq);
            if (!(mr | mw)) begin
                e_st   = 0;
                exp_wb = '{rw, mtr, jmp, rd, alu, 32'd0};
            end else if (lat == 0) begin
                e_st       = TO;
                exp_wb.rw  = 1'b0;
                exp_wb.mtr = 1'b0;
                exp_wb.jmp = 1'b0;
                exp_berr   = 1'b1;
            end else begin
                e_st   = lat;
                exp_wb = '{rw, mtr, jmp, rd, alu, mw ? 32'd0 : rdata};
            end
            chk("rnd_stalls", 32'(st), 32'(e_st));
            chk("rnd_reqs", 32'(rq), 32'(e_st));
            chk_wb("rnd", exp_wb, exp_berr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
